ir_queue: RTL and testbench

Parametrised multi-entry instruction register that replaces the single-word IR between instruction memory (ROM) and the controller. It holds up to DEPTH fetched instruction words in FIFO order and presents the oldest word plus its opcode field to the controller. A consume strobe retires the head word, and a flush strobe discards all held words on a branch or jump.

---
 rtl/ir_queue.sv | 121 ++++++++++++
 tb/tb_ir_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// ir_queue: multi-entry instruction register (FIFO) between instruction ROM
// and the controller. Holds up to DEPTH fetched words in arrival order and
// presents the oldest word and its opcode field. A consume strobe retires
// the head word; a flush strobe discards every held word (branch/jump).
//
// Optional feature macro: IR_QUEUE_OVF_EN -- adds a sticky overflow flag
// that records a load dropped because the queue was full.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   ld        in   load request: write data_in at the tail
//   data_in   in   [WIDTH-1:0] instruction word from ROM
//   adv       in   consume request: retire the head word
//   flush     in   discard all held words (wins over ld and adv)
//   data_out  out  [WIDTH-1:0] head word, 0 when empty
//   opcode    out  [OPC_W-1:0] top OPC_W bits of data_out
//   valid     out  queue holds at least one word
//   full      out  queue holds DEPTH words
//   count     out  [$clog2(DEPTH+1)-1:0] number of held words
//   ovf       out  sticky dropped-load flag (IR_QUEUE_OVF_EN only)
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPC_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       adv,
  input  logic                       flush,
  output logic [WIDTH-1:0]           data_out,
  output logic [OPC_W-1:0]           opcode,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IR_QUEUE_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = adv && w_valid;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push  = ld && (!w_full || w_pop);

  // Storage is not cleared by flush; the empty-state output mask hides it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!flush && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef IR_QUEUE_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_ovf <= 1'b0;
    end else if (ld && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  // All outputs derive from registered state only.
  assign data_out = w_valid ? r_mem[r_rd_ptr] : '0;
  assign opcode   = data_out[WIDTH-1 -: OPC_W];
  assign valid    = w_valid;
  assign full     = w_full;
  assign count    = r_count;

endmodule

// File: tb/tb_ir_queue.sv
module tb_ir_queue;

  logic        clk;
  logic        reset;
  logic        ld;
  logic [15:0] data_in;
  logic        adv;
  logic        flush;
  logic [15:0] data_out;
  logic [3:0]  opcode;
  logic        valid;
  logic        full;
  logic [2:0]  count;
`ifdef IR_QUEUE_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  ir_queue #(.WIDTH(16), .DEPTH(4), .OPC_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld),
    .data_in  (data_in),
    .adv      (adv),
    .flush    (flush),
    .data_out (data_out),
    .opcode   (opcode),
    .valid    (valid),
    .full     (full),
    .count    (count)
`ifdef IR_QUEUE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    ld = 1'b1; data_in = w;
    step();
    ld = 1'b0; data_in = '0;
  endtask

  task automatic pop();
    adv = 1'b1;
    step();
    adv = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld = 1'b0; adv = 1'b0; flush = 1'b0; data_in = '0;
    step(); step();
    checks++;
    if (data_out !== 16'h0 || count !== 3'd0 || valid !== 1'b0 || full !== 1'b0 || opcode !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: data=%h cnt=%0d v=%b f=%b opc=%h, want 0", data_out, count, valid, full, opcode);
    end
    reset = 1'b0;
    step();
    push(16'h1234);
    push(16'h5678);
    checks++;
    if (data_out !== 16'h1234 || count !== 3'd2) begin
      errors++;
      $display("FAIL prefill: data=%h cnt=%0d, want 1234 cnt=2", data_out, count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 16'h0 || count !== 3'd0 || valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h cnt=%0d v=%b f=%b, want all 0", data_out, count, valid, full);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_empty: data=%h cnt=%0d v=%b, want empty", data_out, count, valid);
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hB002; exp_seq[1] = 16'hC003; exp_seq[2] = 16'hD004; exp_seq[3] = 16'h0000;
    push(16'hA001);
    checks++;
    if (data_out !== 16'hA001 || count !== 3'd1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: data=%h cnt=%0d v=%b, want A001 cnt=1 v=1", data_out, count, valid);
    end
    push(16'hB002); push(16'hC003); push(16'hD004);
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || data_out !== 16'hA001 || opcode !== 4'hA) begin
      errors++;
      $display("FAIL fill: f=%b cnt=%0d data=%h opc=%h, want f=1 cnt=4 A001 A", full, count, data_out, opcode);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      checks++;
      if (data_out !== exp_seq[i] || count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain%0d: data=%h cnt=%0d, want %h cnt=%0d", i, data_out, count, exp_seq[i], 3 - i);
      end
    end
    checks++;
    if (valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL drained_flags: v=%b f=%b, want 0 0", valid, full);
    end
  endtask

  task automatic test_full_ld();
    push(16'hA001); push(16'hB002); push(16'hC003); push(16'hD004);
    push(16'hEEEE);
    checks++;
    if (count !== 3'd4 || data_out !== 16'hA001 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_ld_ignored: cnt=%0d data=%h f=%b, want 4 A001 1", count, data_out, full);
    end
`ifdef IR_QUEUE_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b, want 1", ovf);
    end
`endif
  endtask

  task automatic test_full_ld_adv();
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'hC003; exp_seq[1] = 16'hD004; exp_seq[2] = 16'hF005; exp_seq[3] = 16'h0000;
    ld = 1'b1; adv = 1'b1; data_in = 16'hF005;
    step();
    ld = 1'b0; adv = 1'b0; data_in = '0;
    checks++;
    if (count !== 3'd4 || data_out !== 16'hB002 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_swap: cnt=%0d data=%h f=%b, want 4 B002 1", count, data_out, full);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      checks++;
      if (data_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL wrap_drain%0d: data=%h, want %h", i, data_out, exp_seq[i]);
      end
    end
`ifdef IR_QUEUE_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b, want 1", ovf);
    end
`endif
  endtask

  task automatic test_flush();
    push(16'h4444); push(16'h5555);
    flush = 1'b1; ld = 1'b1; adv = 1'b1; data_in = 16'h7777;
    step();
    flush = 1'b0; ld = 1'b0; adv = 1'b0; data_in = '0;
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL flush_priority: cnt=%0d v=%b data=%h, want 0 0 0000", count, valid, data_out);
    end
`ifdef IR_QUEUE_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flush_clear: ovf=%b, want 0", ovf);
    end
`endif
    push(16'h1111);
    checks++;
    if (data_out !== 16'h1111 || count !== 3'd1) begin
      errors++;
      $display("FAIL post_flush_push: data=%h cnt=%0d, want 1111 1", data_out, count);
    end
  endtask

  task automatic test_empty_adv_swap();
    flush = 1'b1;
    step();
    flush = 1'b0;
    pop();
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL empty_adv: cnt=%0d v=%b data=%h, want 0 0 0000", count, valid, data_out);
    end
    push(16'h2222);
    ld = 1'b1; adv = 1'b1; data_in = 16'h3333;
    step();
    ld = 1'b0; adv = 1'b0; data_in = '0;
    checks++;
    if (data_out !== 16'h3333 || count !== 3'd1 || opcode !== 4'h3) begin
      errors++;
      $display("FAIL single_swap: data=%h cnt=%0d opc=%h, want 3333 1 3", data_out, count, opcode);
    end
    pop();
    checks++;
    if (valid !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL single_swap_drain: v=%b data=%h, want 0 0000", valid, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_ld();
    test_full_ld_adv();
    test_flush();
    test_empty_adv_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
